// File: rtl/sb_spi_ctrl.sv
// SB_SPI system-bus master: writes the SPI core configuration after reset, then maps byte requests to SB accesses.
// Optional poll timeout with sticky err (bounded by POLL_LIMIT) enabled by defining SB_SPI_CTRL_TIMEOUT_EN.
module sb_spi_ctrl #(
  parameter logic [3:0]  BUS_ADDR74 = 4'b0000,
  parameter logic [7:0]  CR1_VAL    = 8'h80,
  parameter logic [7:0]  CR2_VAL    = 8'hC0,
  parameter logic [7:0]  BR_VAL     = 8'h05,
  parameter logic [3:0]  CS_MASK    = 4'b0001,
  parameter int unsigned POLL_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       sb_stb,
  output logic       sb_rw,
  output logic [7:0] sb_adr,
  output logic [7:0] sb_dat_w,
  input  logic [7:0] sb_dat_r,
  input  logic       sb_ack,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic       cmd_last,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       init_done,
  output logic       busy,
  output logic       err
);

  localparam logic [3:0] LO_CR0  = 4'h8;
  localparam logic [3:0] LO_CR1  = 4'h9;
  localparam logic [3:0] LO_CR2  = 4'hA;
  localparam logic [3:0] LO_BR   = 4'hB;
  localparam logic [3:0] LO_SR   = 4'hC;
  localparam logic [3:0] LO_TXDR = 4'hD;
  localparam logic [3:0] LO_RXDR = 4'hE;
  localparam logic [3:0] LO_CSR  = 4'hF;
  localparam int unsigned SR_TIP  = 7;
  localparam int unsigned SR_TRDY = 4;
  localparam int unsigned SR_RRDY = 3;

  typedef enum logic [3:0] {
    INIT_CR0, INIT_CR1, INIT_CR2, INIT_BR, INIT_CSR,
    IDLE, CS_ON, POLL_TRDY, WR_TX, POLL_RRDY, RD_RX, RSP, POLL_TIP, CS_OFF
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_stb, w_stb_nxt;
  logic       r_rw, w_rw_nxt;
  logic [7:0] r_adr, w_adr_nxt;
  logic [7:0] r_dat_w, w_dat_nxt;
  logic       r_cmd_ready, w_cmd_ready_nxt;
  logic       r_rsp_valid, w_rsp_valid_nxt;
  logic [7:0] r_rsp_data, w_rsp_data_nxt;
  logic       r_init_done, w_init_done_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_cs_held, w_cs_held_nxt;
  logic [7:0] r_byte, w_byte_nxt;
  logic       r_last, w_last_nxt;

  logic       w_acc, w_acc_rw, w_done, w_poll_ok;
  logic [3:0] w_acc_lo;
  logic [7:0] w_acc_dat;

`ifdef SB_SPI_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(POLL_LIMIT + 1) > 8) ? $clog2(POLL_LIMIT + 1) : 8;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_err, w_err_nxt;
`endif

  assign w_done = r_stb & sb_ack;

  // Access each state performs: direction, register and write data.
  always_comb begin
    w_acc     = 1'b1;
    w_acc_rw  = 1'b0;
    w_acc_lo  = LO_SR;
    w_acc_dat = 8'h00;
    case (r_state)
      INIT_CR0: begin w_acc_rw = 1'b1; w_acc_lo = LO_CR0; end
      INIT_CR1: begin w_acc_rw = 1'b1; w_acc_lo = LO_CR1; w_acc_dat = CR1_VAL; end
      INIT_CR2: begin w_acc_rw = 1'b1; w_acc_lo = LO_CR2; w_acc_dat = CR2_VAL; end
      INIT_BR:  begin w_acc_rw = 1'b1; w_acc_lo = LO_BR;  w_acc_dat = BR_VAL; end
      INIT_CSR: begin w_acc_rw = 1'b1; w_acc_lo = LO_CSR; w_acc_dat = 8'h0F; end
      CS_ON:    begin w_acc_rw = 1'b1; w_acc_lo = LO_CSR; w_acc_dat = {4'h0, ~CS_MASK}; end
      WR_TX:    begin w_acc_rw = 1'b1; w_acc_lo = LO_TXDR; w_acc_dat = r_byte; end
      RD_RX:    w_acc_lo = LO_RXDR;
      CS_OFF:   begin w_acc_rw = 1'b1; w_acc_lo = LO_CSR; w_acc_dat = 8'h0F; end
      IDLE, RSP: w_acc = 1'b0;
      default:  ;
    endcase
  end

  always_comb begin
    w_poll_ok = 1'b1;
    case (r_state)
      POLL_TRDY: w_poll_ok = sb_dat_r[SR_TRDY];
      POLL_RRDY: w_poll_ok = sb_dat_r[SR_RRDY];
      POLL_TIP:  w_poll_ok = ~sb_dat_r[SR_TIP];
      default:   ;
    endcase
  end

  // Next state and next values of every registered output.
  always_comb begin
    w_state_nxt     = r_state;
    w_stb_nxt       = r_stb;
    w_rw_nxt        = r_rw;
    w_adr_nxt       = r_adr;
    w_dat_nxt       = r_dat_w;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_init_done_nxt = r_init_done;
    w_busy_nxt      = r_busy;
    w_cs_held_nxt   = r_cs_held;
    w_byte_nxt      = r_byte;
    w_last_nxt      = r_last;
`ifdef SB_SPI_CTRL_TIMEOUT_EN
    w_cnt_nxt       = r_cnt;
    w_err_nxt       = r_err;
`endif
    if (w_acc && !r_stb) begin
      w_stb_nxt = 1'b1;
      w_rw_nxt  = w_acc_rw;
      w_adr_nxt = {BUS_ADDR74, w_acc_lo};
      w_dat_nxt = w_acc_dat;
    end else if (w_done) begin
      w_stb_nxt = 1'b0;
      case (r_state)
        INIT_CR0:  w_state_nxt = INIT_CR1;
        INIT_CR1:  w_state_nxt = INIT_CR2;
        INIT_CR2:  w_state_nxt = INIT_BR;
        INIT_BR:   w_state_nxt = INIT_CSR;
        INIT_CSR:  begin w_init_done_nxt = 1'b1; w_state_nxt = IDLE; end
        CS_ON:     begin w_cs_held_nxt = 1'b1; w_state_nxt = POLL_TRDY; end
        POLL_TRDY: if (w_poll_ok) w_state_nxt = WR_TX;
        WR_TX:     w_state_nxt = POLL_RRDY;
        POLL_RRDY: if (w_poll_ok) w_state_nxt = RD_RX;
        RD_RX: begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = sb_dat_r;
          w_state_nxt     = RSP;
        end
        POLL_TIP:  if (w_poll_ok) w_state_nxt = CS_OFF;
        CS_OFF: begin
          w_cs_held_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = IDLE;
        end
        default: ;
      endcase
`ifdef SB_SPI_CTRL_TIMEOUT_EN
      // A poll that exhausts its read budget releases CS without a response.
      if (r_state inside {POLL_TRDY, POLL_RRDY, POLL_TIP}) begin
        if (w_poll_ok) begin
          w_cnt_nxt = '0;
        end else if (32'(r_cnt) + 32'd1 >= POLL_LIMIT) begin
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = CS_OFF;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
`endif
    end
    if (r_state == IDLE && cmd_valid && r_cmd_ready) begin
      w_byte_nxt  = cmd_data;
      w_last_nxt  = cmd_last;
      w_busy_nxt  = 1'b1;
      w_state_nxt = r_cs_held ? POLL_TRDY : CS_ON;
    end
    if (r_state == RSP) w_state_nxt = r_last ? POLL_TIP : IDLE;
    w_cmd_ready_nxt = (w_state_nxt == IDLE) & w_init_done_nxt & ~w_stb_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= INIT_CR0;
      r_stb       <= 1'b0;
      r_rw        <= 1'b0;
      r_adr       <= 8'h00;
      r_dat_w     <= 8'h00;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_init_done <= 1'b0;
      r_busy      <= 1'b0;
      r_cs_held   <= 1'b0;
      r_byte      <= 8'h00;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stb       <= w_stb_nxt;
      r_rw        <= w_rw_nxt;
      r_adr       <= w_adr_nxt;
      r_dat_w     <= w_dat_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_init_done <= w_init_done_nxt;
      r_busy      <= w_busy_nxt;
      r_cs_held   <= w_cs_held_nxt;
      r_byte      <= w_byte_nxt;
      r_last      <= w_last_nxt;
    end
  end

`ifdef SB_SPI_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign sb_stb    = r_stb;
  assign sb_rw     = r_rw;
  assign sb_adr    = r_adr;
  assign sb_dat_w  = r_dat_w;
  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign init_done = r_init_done;
  assign busy      = r_busy;

endmodule

// File: doc/sb_spi_ctrl.md
Name: sb_spi_ctrl

Overview:
Sequencer that drives the system-bus (SB) port of the SB_SPI hard IP as SPI master. It runs a configuration write sequence after reset, then turns a byte-stream request interface into SB register accesses. Each byte is handled as: chip-select write, TRDY poll, TXDR write, RRDY poll, RXDR read, response. Sits between the motion/command logic and the SB_SPI instance.

Parameters:
BUS_ADDR74, 4'b0000, upper address nibble of the target SB_SPI; must match the instance's BUS_ADDR74.
CR1_VAL, 8'h80, SPICR1 value (core enable).
CR2_VAL, 8'hC0, SPICR2 value (master mode, MCSNO held by software).
BR_VAL, 8'h05, SPIBR clock divider.
CS_MASK, 4'b0001, MCSNO line(s) driven low while selected.
POLL_LIMIT, 255, max status reads per poll; only used with the optional feature.

Ports:
clk  in  1  system clock, also drives SBCLKI
rst_n  in  1  asynchronous active-low reset
sb_stb  out  1  to SBSTBI
sb_rw  out  1  to SBRWI; 1 = write
sb_adr  out  8  to SBADRI7..0
sb_dat_w  out  8  to SBDATI7..0
sb_dat_r  in  8  from SBDATO7..0
sb_ack  in  1  from SBACKO
cmd_valid  in  1  byte request valid
cmd_ready  out  1  byte request accepted
cmd_data  in  8  byte to shift out
cmd_last  in  1  release CS after this byte
rsp_valid  out  1  one-cycle pulse, received byte valid
rsp_data  out  8  received byte
init_done  out  1  configuration sequence complete
busy  out  1  transfer in progress or CS held
err  out  1  poll timeout, sticky (optional feature only; tied 0 otherwise)

Behaviour:
- Clock and reset: single clock domain on clk. rst_n is asynchronous and active-low.
- Reset values: all outputs 0, sb_adr 8'h00, FSM in INIT_CR0.
- Reset mid-transfer aborts the transfer immediately. No CS release is issued; the INIT sequence rewrites SPICSR.
- Register addresses: {BUS_ADDR74, lo}, with lo = CR0 4'h8, CR1 4'h9, CR2 4'hA, BR 4'hB, SR 4'hC, TXDR 4'hD, RXDR 4'hE, CSR 4'hF.
- SR bits: TRDY = bit4, RRDY = bit3, TIP = bit7.
- SB access rule:
  - Raise sb_stb with sb_adr, sb_rw and sb_dat_w stable.
  - Hold all of them until the cycle sb_ack = 1.
  - Drop sb_stb the next cycle; strobe is low for at least 1 cycle between accesses.
  - For reads, capture sb_dat_r in the ack cycle.
  - sb_ack while sb_stb = 0 is ignored.
- INIT states (writes, in order): CR0 <= 8'h00, CR1 <= CR1_VAL, CR2 <= CR2_VAL, BR <= BR_VAL, CSR <= 8'h0F (all CS high). Then init_done <= 1 and go to IDLE.
- IDLE: cmd_ready = init_done & ~sb_stb. On cmd_valid & cmd_ready, latch cmd_data and cmd_last, set busy, then:
  - go to CS_ON if CS is not held;
  - go to POLL_TRDY if CS is already held.
- CS_ON: write CSR <= ~{4'b0, CS_MASK} (low nibble). Set the cs_held flag.
- POLL_TRDY: read SR, repeat until TRDY = 1.
- WR_TX: write TXDR <= latched byte.
- POLL_RRDY: read SR, repeat until RRDY = 1.
- RD_RX: read RXDR, then go to RSP.
- RSP: rsp_data <= read value and rsp_valid = 1 for exactly 1 cycle. Next state:
  - POLL_TIP if cmd_last = 1;
  - IDLE otherwise. CS stays held and busy stays 1.
- POLL_TIP: read SR, repeat until TIP = 0.
- CS_OFF: write CSR <= 8'h0F. Clear cs_held and busy. Go to IDLE.
- cmd_valid is not accepted outside IDLE, or in IDLE while init_done = 0.
- Minimum latency from accept to rsp_valid, with every poll passing first read and 1-cycle acks: 2 cycles per access × 4 accesses (or 5 with CS_ON) + 1.

Optional Feature:
- Macro: SB_SPI_CTRL_TIMEOUT_EN.
- With it defined:
  - An 8-bit-or-wider poll counter counts reads in each POLL_* state.
  - When the count reaches POLL_LIMIT without the condition met, set err (sticky until reset), write CSR <= 8'h0F, clear cs_held and busy, and return to IDLE with no rsp_valid.
  - Further commands are still accepted.
- Without it: polls are unbounded, no counter is present, and err is tied 0.

Test Plan:
- Reset release with a 1-cycle-ack SB model -> writes observed in order: 0x08<=00, 0x09<=80, 0x0A<=C0, 0x0B<=05, 0x0F<=0F. Then init_done = 1; cmd_ready stays 0 before that.
- Single byte 0xA5 with cmd_last = 1, model returns RX 0x3C -> accesses in order:
  - write 0x0F <= 0E;
  - read 0x0C (TRDY);
  - write 0x0D <= A5;
  - read 0x0C (RRDY);
  - read 0x0E;
  - rsp_valid pulse with rsp_data = 3C;
  - TIP poll, then write 0x0F <= 0F; busy drops.
- Three-byte burst 11, 22, 33 (last on 33) -> exactly one CS-on write and one CS-off write; three rsp pulses in order.
- Ack delayed 3 cycles and TRDY low for first 4 SR reads -> sb_stb and sb_adr stable until ack; exactly 5 SR reads before the TXDR write.
- rst_n asserted during POLL_RRDY -> all outputs 0 asynchronously; INIT sequence reruns; no rsp_valid.
- With SB_SPI_CTRL_TIMEOUT_EN and POLL_LIMIT = 4, RRDY never set -> 4 SR reads, err = 1, CS-off write, return to IDLE; the next command completes normally with err still 1.
